// File: rtl/ysyx_25030093_pc_pkg.sv
// Shared encodings for the next-PC generator: completion selects, FSM states, trap cause.
package ysyx_25030093_pc_pkg;

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_JAL  = 3'b001;
  localparam logic [2:0] SEL_JALR = 3'b010;
  localparam logic [2:0] SEL_BR   = 3'b011;
  localparam logic [2:0] SEL_CSR  = 3'b100;
  localparam logic [2:0] SEL_HOLD = 3'b111;

  localparam int CAUSE_IMISALIGN = 0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } pc_state_t;

endpackage

// File: rtl/ysyx_25030093_pc_tgt.sv
// Combinational next-PC target selection and instruction-address misalign detection.
module ysyx_25030093_pc_tgt
  import ysyx_25030093_pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int C_EXT  = 0,
  parameter int ILEN_B = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      sel,
  input  logic            taken,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] csr_tgt,
  output logic [XLEN-1:0] tgt,
  output logic            mis
);

  localparam logic [XLEN-1:0] STEP = XLEN'(ILEN_B);

  logic [XLEN-1:0] seq_tgt;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic            chk;
  logic            bad_align;

  assign seq_tgt  = pc + STEP;
  assign rel_tgt  = pc + imm;
  assign jalr_sum = rs1 + imm;

  always_comb begin
    tgt = seq_tgt;
    chk = 1'b0;
    case (sel)
      SEL_JAL: begin
        tgt = rel_tgt;
        chk = 1'b1;
      end
      SEL_JALR: begin
        tgt = {jalr_sum[XLEN-1:1], 1'b0};
        chk = 1'b1;
      end
      SEL_BR: begin
        if (taken) begin
          tgt = rel_tgt;
          chk = 1'b1;
        end
      end
      SEL_CSR: begin
        tgt = csr_tgt;
        chk = 1'b1;
      end
      SEL_HOLD: tgt = pc;
      default:  tgt = seq_tgt;
    endcase
  end

  // Sequential and hold targets are aligned by construction, so only redirects are checked.
  assign bad_align = (C_EXT != 0) ? tgt[0] : (tgt[1] | tgt[0]);
  assign mis       = chk & bad_align;

endmodule

// File: rtl/ysyx_25030093_pc_gen.sv
// Handshaked next-PC generator: issues pc to the IFU, consumes one EXU completion, redirects on misalign.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never depends on ready.
module ysyx_25030093_pc_gen
  import ysyx_25030093_pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter int              C_EXT     = 0,
  parameter int              ILEN_B    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [2:0]      upd_sel,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_rs1,
  input  logic [XLEN-1:0] upd_imm,
  input  logic [XLEN-1:0] upd_csr_tgt,
  input  logic [XLEN-1:0] trap_vec,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_tval,
  output logic [1:0]      dbg_state
);

  pc_state_t       state;
  logic [XLEN-1:0] tgt;
  logic            mis;

  ysyx_25030093_pc_tgt #(
    .XLEN   (XLEN),
    .C_EXT  (C_EXT),
    .ILEN_B (ILEN_B)
  ) u_tgt (
    .pc      (pc),
    .sel     (upd_sel),
    .taken   (upd_taken),
    .rs1     (upd_rs1),
    .imm     (upd_imm),
    .csr_tgt (upd_csr_tgt),
    .tgt     (tgt),
    .mis     (mis)
  );

  // Handshake flags are registered alongside the state so exactly one side is ever open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      pc_valid   <= 1'b0;
      upd_ready  <= 1'b0;
      trap_valid <= 1'b0;
      trap_tval  <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          pc_valid <= 1'b1;
        end
        FETCH: begin
          if (pc_ready) begin
            state     <= EXEC;
            pc_valid  <= 1'b0;
            upd_ready <= 1'b1;
          end
        end
        EXEC: begin
          if (upd_valid) begin
            upd_ready <= 1'b0;
            if (mis) begin
              state      <= TRAP;
              trap_valid <= 1'b1;
              trap_tval  <= tgt;
            end else begin
              state    <= FETCH;
              pc       <= tgt;
              pc_valid <= 1'b1;
            end
          end
        end
        TRAP: begin
          state      <= FETCH;
          pc         <= trap_vec;
          trap_valid <= 1'b0;
          pc_valid   <= 1'b1;
        end
        default: begin
          state      <= BOOT;
          pc_valid   <= 1'b0;
          upd_ready  <= 1'b0;
          trap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_25030093_pc_gen.sv
// Directed bench for the next-PC generator: two instances (4-byte and 2-byte alignment), scoreboarded fetch/trap outputs.
module tb_ysyx_25030093_pc_gen;
  import ysyx_25030093_pc_pkg::*;

  localparam logic [31:0] RST_VEC = 32'h8000_0000;
  localparam logic [31:0] TVEC    = 32'h8000_1000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cur;
  logic        rst_n_v, pc_ready_v, upd_valid_v;
  logic [2:0]  sel_v;
  logic        taken_v;
  logic [31:0] rs1_v, imm_v, csr_v, trap_vec_v;

  logic        rst0, rst1, prdy0, prdy1, uval0, uval1;
  logic [31:0] pc0, pc1, tval0, tval1;
  logic        pv0, pv1, ur0, ur1, tv0, tv1;
  logic [1:0]  st0, st1;

  assign rst0  = rst_n_v & ~cur;
  assign rst1  = rst_n_v & cur;
  assign prdy0 = pc_ready_v & ~cur;
  assign prdy1 = pc_ready_v & cur;
  assign uval0 = upd_valid_v & ~cur;
  assign uval1 = upd_valid_v & cur;

  ysyx_25030093_pc_gen dut0 (
    .clk(clk), .rst_n(rst0), .pc(pc0), .pc_valid(pv0), .pc_ready(prdy0),
    .upd_valid(uval0), .upd_ready(ur0), .upd_sel(sel_v), .upd_taken(taken_v),
    .upd_rs1(rs1_v), .upd_imm(imm_v), .upd_csr_tgt(csr_v), .trap_vec(trap_vec_v),
    .trap_valid(tv0), .trap_tval(tval0), .dbg_state(st0)
  );

  ysyx_25030093_pc_gen #(.C_EXT(1)) dut1 (
    .clk(clk), .rst_n(rst1), .pc(pc1), .pc_valid(pv1), .pc_ready(prdy1),
    .upd_valid(uval1), .upd_ready(ur1), .upd_sel(sel_v), .upd_taken(taken_v),
    .upd_rs1(rs1_v), .upd_imm(imm_v), .upd_csr_tgt(csr_v), .trap_vec(trap_vec_v),
    .trap_valid(tv1), .trap_tval(tval1), .dbg_state(st1)
  );

  logic [31:0] pc_m, tval_m;
  logic        pv_m, ur_m, tv_m, rst_m;
  logic [1:0]  st_m;
  assign pc_m   = cur ? pc1 : pc0;
  assign tval_m = cur ? tval1 : tval0;
  assign pv_m   = cur ? pv1 : pv0;
  assign ur_m   = cur ? ur1 : ur0;
  assign tv_m   = cur ? tv1 : tv0;
  assign st_m   = cur ? st1 : st0;
  assign rst_m  = cur ? rst1 : rst0;

  // scoreboard
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_tval_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        prev_trap = 1'b0;
  logic [31:0] mon_e;
  always @(negedge clk) begin
    if (!rst_m) begin
      prev_trap = 1'b0;
    end else begin
      if (pv_m && pc_ready_v) begin
        if (exp_pc_q.size() == 0) begin
          n_errors++;
          $display("FAIL fetch_unexpected: got pc %h expected no fetch", pc_m);
        end else begin
          mon_e = exp_pc_q.pop_front();
          check("fetch_pc", pc_m, mon_e);
        end
      end
      if (tv_m) begin
        if (prev_trap) begin
          n_errors++;
          $display("FAIL trap_width: got trap_valid 1 for 2 cycles expected 1 cycle");
        end
        if (exp_tval_q.size() == 0) begin
          n_errors++;
          $display("FAIL trap_unexpected: got tval %h expected no trap", tval_m);
        end else begin
          mon_e = exp_tval_q.pop_front();
          check("trap_tval", tval_m, mon_e);
        end
      end
      prev_trap = tv_m;
    end
  end

  // drivers
  task automatic do_fetch(input logic [31:0] exp);
    bit ok = 1'b0;
    exp_pc_q.push_back(exp);
    @(posedge clk); #1;
    pc_ready_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pv_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_errors++;
      $display("FAIL fetch_timeout: got no pc_valid expected pc %h", exp);
    end
    @(posedge clk); #1;
    pc_ready_v = 1'b0;
  endtask

  task automatic do_upd(input logic [2:0] sel, input logic taken, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] csr);
    bit ok = 1'b0;
    @(posedge clk); #1;
    sel_v = sel; taken_v = taken; rs1_v = rs1; imm_v = imm; csr_v = csr;
    upd_valid_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ur_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_errors++;
      $display("FAIL upd_timeout: got no upd_ready expected accept of sel %b", sel);
    end
    @(posedge clk); #1;
    upd_valid_v = 1'b0;
  endtask

  initial begin
    cur = 1'b0; rst_n_v = 1'b0; pc_ready_v = 1'b0; upd_valid_v = 1'b0;
    sel_v = SEL_SEQ; taken_v = 1'b0; rs1_v = '0; imm_v = '0; csr_v = '0;
    trap_vec_v = TVEC;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc_m, RST_VEC);
    check("rst_pc_valid", 32'(pv_m), 32'd0);
    check("rst_upd_ready", 32'(ur_m), 32'd0);
    check("rst_trap_valid", 32'(tv_m), 32'd0);
    check("rst_trap_tval", tval_m, 32'd0);
    check("rst_state", 32'(st_m), 32'(BOOT));
    @(posedge clk); #1;
    rst_n_v = 1'b1;
    @(negedge clk);
    check("boot_pc_valid", 32'(pv_m), 32'd0);
    @(negedge clk);
    check("fetch_pc_valid", 32'(pv_m), 32'd1);

    // completion offered early must wait for EXEC; pc held while IFU stalls
    sel_v = SEL_SEQ;
    upd_valid_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_pc", pc_m, RST_VEC);
      check("stall_state", 32'(st_m), 32'(FETCH));
      @(negedge clk);
    end
    do_fetch(32'h8000_0000);
    @(posedge clk); #1;
    upd_valid_v = 1'b0;
    do_fetch(32'h8000_0004);

    do_upd(SEL_BR, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0);
    @(negedge clk);
    check("latency_nontrap", 32'(pv_m), 32'd1);
    do_fetch(32'h8000_0008);

    do_upd(SEL_JAL, 1'b0, 32'h0, 32'h0000_0010, 32'h0);
    do_fetch(32'h8000_0018);

    exp_tval_q.push_back(32'h8000_0102);
    do_upd(SEL_JALR, 1'b0, 32'h8000_0101, 32'h0000_0002, 32'h0);
    @(negedge clk);
    check("trap_cycle_pc_valid", 32'(pv_m), 32'd0);
    check("trap_cycle_state", 32'(st_m), 32'(TRAP));
    @(negedge clk);
    check("latency_trap", 32'(pv_m), 32'd1);
    do_fetch(TVEC);

    do_upd(SEL_HOLD, 1'b0, 32'h0, 32'h0000_0040, 32'h0);
    do_fetch(TVEC);
    do_upd(SEL_BR, 1'b1, 32'h0, 32'hFFFF_F800, 32'h0);
    do_fetch(32'h8000_0800);
    do_upd(SEL_CSR, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC);
    do_upd(SEL_SEQ, 1'b0, 32'h0, 32'h0, 32'h0);
    do_fetch(32'h0000_0000);
    do_upd(3'b101, 1'b1, 32'h0, 32'h0000_0100, 32'h0);
    do_fetch(32'h0000_0004);
    exp_tval_q.push_back(32'h0000_0006);
    do_upd(SEL_JAL, 1'b0, 32'h0, 32'h0000_0002, 32'h0);
    do_fetch(TVEC);

    // reset while a completion is being offered in EXEC
    @(posedge clk); #1;
    sel_v = SEL_JAL; imm_v = 32'h0000_0040; upd_valid_v = 1'b1;
    @(negedge clk);
    check("exec_before_rst", 32'(ur_m), 32'd1);
    rst_n_v = 1'b0;
    #1;
    check("exec_rst_pc", pc_m, RST_VEC);
    check("exec_rst_upd_ready", 32'(ur_m), 32'd0);
    check("exec_rst_state", 32'(st_m), 32'(BOOT));
    upd_valid_v = 1'b0;
    @(posedge clk); #1;
    rst_n_v = 1'b1;
    do_fetch(RST_VEC);

    // reset during the trap report cycle
    exp_tval_q.push_back(32'h8000_0002);
    do_upd(SEL_JAL, 1'b0, 32'h0, 32'h0000_0002, 32'h0);
    @(negedge clk);
    #1;
    rst_n_v = 1'b0;
    #1;
    check("trap_rst_trap_valid", 32'(tv_m), 32'd0);
    check("trap_rst_tval", tval_m, 32'd0);
    check("trap_rst_pc", pc_m, RST_VEC);
    check("trap_rst_state", 32'(st_m), 32'(BOOT));
    @(posedge clk); #1;
    rst_n_v = 1'b1;
    do_fetch(RST_VEC);

    // compressed-alignment instance
    @(posedge clk); #1;
    rst_n_v = 1'b0;
    @(posedge clk); #1;
    cur = 1'b1;
    @(posedge clk); #1;
    rst_n_v = 1'b1;
    do_fetch(RST_VEC);
    do_upd(SEL_JALR, 1'b0, 32'h8000_0101, 32'h0000_0002, 32'h0);
    do_fetch(32'h8000_0102);
    exp_tval_q.push_back(32'h8000_0103);
    do_upd(SEL_JAL, 1'b0, 32'h0, 32'h0000_0001, 32'h0);
    do_fetch(TVEC);

    repeat (3) @(negedge clk);
    check("pc_q_drained", 32'(exp_pc_q.size()), 32'd0);
    check("tval_q_drained", 32'(exp_tval_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no end of test expected finish before 50000");
    $fatal(1);
  end

endmodule
